// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS decode stage: widths, opcodes, instruction
// field positions and the opcode-to-control decoder.
package mips_pkg;

   localparam int XLEN    = 32;
   localparam int NREGS   = 32;
   localparam int RADDR_W = $clog2(NREGS);
   localparam logic [XLEN-1:0] RESET_PC = '0;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int SH_MSB  = 10;
   localparam int SH_LSB  = 6;
   localparam int FN_MSB  = 5;
   localparam int FN_LSB  = 0;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;
   localparam int TGT_MSB = 25;
   localparam int TGT_LSB = 0;

   typedef struct packed {
      logic reg_write;
      logic reg_dst;
      logic alu_src;
      logic mem_read;
      logic mem_write;
   } ctrl_t;

   typedef struct packed {
      ctrl_t ctrl;
      logic  illegal;
   } dec_t;

   // Branches and jumps carry no datapath controls; unknown opcodes become NOPs.
   function automatic dec_t decode_op(input logic [5:0] op);
      dec_t d;
      d = '0;
      case (op)
         OP_RTYPE: begin
            d.ctrl.reg_write = 1'b1;
            d.ctrl.reg_dst   = 1'b1;
         end
         OP_LW: begin
            d.ctrl.reg_write = 1'b1;
            d.ctrl.alu_src   = 1'b1;
            d.ctrl.mem_read  = 1'b1;
         end
         OP_SW: begin
            d.ctrl.alu_src   = 1'b1;
            d.ctrl.mem_write = 1'b1;
         end
         OP_ADDI: begin
            d.ctrl.reg_write = 1'b1;
            d.ctrl.alu_src   = 1'b1;
         end
         OP_BEQ, OP_J: d = '0;
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one write port, r0 hardwired to zero, synchronous clear.
module mips_regfile
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [RADDR_W-1:0] rs_addr,
   input  logic [RADDR_W-1:0] rt_addr,
   output logic [XLEN-1:0]    rs_data,
   output logic [XLEN-1:0]    rt_data,
   input  logic               we,
   input  logic [RADDR_W-1:0] waddr,
   input  logic [XLEN-1:0]    wdata
);

   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // A same-cycle writeback is forwarded so decode never sees a stale value.
   assign rs_data = (rs_addr == '0)              ? '0    :
                    (we && (waddr == rs_addr))   ? wdata : regs[rs_addr];
   assign rt_data = (rt_addr == '0)              ? '0    :
                    (we && (waddr == rt_addr))   ? wdata : regs[rt_addr];

endmodule

// File: rtl/id_decode_stage.sv
// MIPS instruction-decode stage: IF/ID register, register file, control decode,
// load-use hazard detection, J/BEQ resolution and the ID/EX register.
module id_decode_stage
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [XLEN-1:0]    if_instr,
   input  logic [XLEN-1:0]    if_pc,
   input  logic               if_valid,
   input  logic               wb_we,
   input  logic [RADDR_W-1:0] wb_addr,
   input  logic [XLEN-1:0]    wb_data,
   input  logic               ex_mem_read,
   input  logic [RADDR_W-1:0] ex_rt,
   output logic               stall,
   output logic               jump,
   output logic [XLEN-1:0]    jmpammt,
   output logic               id_ex_valid,
   output logic [XLEN-1:0]    id_ex_pc,
   output logic [XLEN-1:0]    id_ex_rs_data,
   output logic [XLEN-1:0]    id_ex_rt_data,
   output logic [XLEN-1:0]    id_ex_imm,
   output logic [RADDR_W-1:0] id_ex_rs,
   output logic [RADDR_W-1:0] id_ex_rt,
   output logic [RADDR_W-1:0] id_ex_rd,
   output logic [4:0]         id_ex_shamt,
   output logic [5:0]         id_ex_funct,
   output logic               id_ex_reg_write,
   output logic               id_ex_reg_dst,
   output logic               id_ex_alu_src,
   output logic               id_ex_mem_read,
   output logic               id_ex_mem_write,
   output logic               id_ex_illegal
);

   // Flow control toward fetch: if_valid qualifies if_instr/if_pc; while stall is
   // high fetch must hold its PC and present the same word, and when jump is high
   // the word on if_* this cycle is discarded and fetch redirects to PC+4+jmpammt.
   logic [XLEN-1:0]    if_id_instr;
   logic [XLEN-1:0]    if_id_pc;
   logic               if_id_valid;

   logic [5:0]         op;
   logic [RADDR_W-1:0] rs, rt, rd;
   logic [4:0]         shamt;
   logic [5:0]         funct;
   logic [15:0]        imm;
   logic [25:0]        target;
   logic [XLEN-1:0]    rs_data, rt_data;
   dec_t               dec;
   ctrl_t              id_ex_ctrl;

   assign op     = if_id_instr[OP_MSB:OP_LSB];
   assign rs     = if_id_instr[RS_MSB:RS_LSB];
   assign rt     = if_id_instr[RT_MSB:RT_LSB];
   assign rd     = if_id_instr[RD_MSB:RD_LSB];
   assign shamt  = if_id_instr[SH_MSB:SH_LSB];
   assign funct  = if_id_instr[FN_MSB:FN_LSB];
   assign imm    = if_id_instr[IMM_MSB:IMM_LSB];
   assign target = if_id_instr[TGT_MSB:TGT_LSB];
   assign dec    = decode_op(op);

   mips_regfile u_regfile (
      .clk     (clk),
      .reset   (reset),
      .rs_addr (rs),
      .rt_addr (rt),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .we      (wb_we),
      .waddr   (wb_addr),
      .wdata   (wb_data)
   );

   assign stall = if_id_valid && ex_mem_read && (ex_rt != '0) &&
                  ((ex_rt == rs) || (ex_rt == rt));

   // Branch compare uses the bypassed operands, so a same-cycle writeback counts.
   always_comb begin
      jump    = 1'b0;
      jmpammt = '0;
      if (if_id_valid && !stall) begin
         if (op == OP_J) begin
            jump    = 1'b1;
            jmpammt = {{4{target[25]}}, target, 2'b00};
         end else if (op == OP_BEQ) begin
            jump    = (rs_data == rt_data);
            jmpammt = {{14{imm[15]}}, imm, 2'b00};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_id_instr <= '0;
         if_id_pc    <= RESET_PC;
         if_id_valid <= 1'b0;
      end else if (stall) begin
         if_id_instr <= if_id_instr;
         if_id_pc    <= if_id_pc;
         if_id_valid <= if_id_valid;
      end else if (jump) begin
         if_id_valid <= 1'b0;
      end else begin
         if_id_instr <= if_instr;
         if_id_pc    <= if_pc;
         if_id_valid <= if_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         id_ex_valid   <= 1'b0;
         id_ex_pc      <= RESET_PC;
         id_ex_rs_data <= '0;
         id_ex_rt_data <= '0;
         id_ex_imm     <= '0;
         id_ex_rs      <= '0;
         id_ex_rt      <= '0;
         id_ex_rd      <= '0;
         id_ex_shamt   <= '0;
         id_ex_funct   <= '0;
         id_ex_ctrl    <= '0;
         id_ex_illegal <= 1'b0;
      end else begin
         id_ex_pc      <= if_id_pc;
         id_ex_rs_data <= rs_data;
         id_ex_rt_data <= rt_data;
         id_ex_imm     <= {{16{imm[15]}}, imm};
         id_ex_rs      <= rs;
         id_ex_rt      <= rt;
         id_ex_rd      <= rd;
         id_ex_shamt   <= shamt;
         id_ex_funct   <= funct;
         if (stall) begin
            id_ex_valid   <= 1'b0;
            id_ex_ctrl    <= '0;
            id_ex_illegal <= 1'b0;
         end else begin
            id_ex_valid   <= if_id_valid;
            id_ex_ctrl    <= if_id_valid ? dec.ctrl : '0;
            id_ex_illegal <= if_id_valid && dec.illegal;
         end
      end
   end

   assign id_ex_reg_write = id_ex_ctrl.reg_write;
   assign id_ex_reg_dst   = id_ex_ctrl.reg_dst;
   assign id_ex_alu_src   = id_ex_ctrl.alu_src;
   assign id_ex_mem_read  = id_ex_ctrl.mem_read;
   assign id_ex_mem_write = id_ex_ctrl.mem_write;

endmodule
